// File: rtl/set_count_gen.sv
// set_count_gen: counts lattice points (x,y in 1..GRID_N) that belong to a
// set expression over up to three circles A, B, C. LANES points are tested
// per clock; the job is started by en and reported by a one-cycle valid pulse.
//
// Handshake: en is sampled only while busy=0 (state IDLE). busy rises on the
// capture edge and stays high until the edge that drops valid. valid is a
// single-cycle pulse qualifying candidate; candidate then holds until the next
// job completes. en during busy is ignored and inputs are not re-sampled.
module set_count_gen #(
  parameter int GRID_N  = 8,
  parameter int COORD_W = 4,
  parameter int LANES   = 4,
  parameter int CNT_W   = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [6*COORD_W-1:0]   central,
  input  logic [3*COORD_W-1:0]   radius,
  input  logic [2:0]             mode,
  output logic                   busy,
  output logic                   valid,
  output logic [CNT_W-1:0]       candidate
);

  localparam int TOTAL     = GRID_N * GRID_N;
  localparam int LAST_BASE = TOTAL - LANES;
  localparam int IDX_W     = $clog2(TOTAL + LANES);
  localparam int SQ_W      = 2 * COORD_W + 1;

  // Parameter sanity: reject configurations the datapath cannot handle.
  if ((TOTAL % LANES) != 0) begin : g_bad_lanes
    $error("set_count_gen: GRID_N*GRID_N must be divisible by LANES");
  end
  if ((GRID_N < 2) || (GRID_N > (2 ** COORD_W) - 1)) begin : g_bad_grid
    $error("set_count_gen: GRID_N out of range for COORD_W");
  end
  if ((2 ** CNT_W) <= TOTAL) begin : g_bad_cnt
    $error("set_count_gen: CNT_W too narrow for GRID_N*GRID_N");
  end

  // FSM state is kept as a named enum so checkers can bind to it directly.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                 state;
  logic [6*COORD_W-1:0]   cen_q;
  logic [3*COORD_W-1:0]   rad_q;
  logic [2:0]             mode_q;
  logic [IDX_W-1:0]       base;
  logic [CNT_W-1:0]       acc;
  logic [LANES-1:0]       lane_hit;
  logic [CNT_W-1:0]       hit_cnt;

  logic [COORD_W-1:0] ax, ay, bx, by, cx, cy, ar, br, cr;
  assign ax = cen_q[6*COORD_W-1 -: COORD_W];
  assign ay = cen_q[5*COORD_W-1 -: COORD_W];
  assign bx = cen_q[4*COORD_W-1 -: COORD_W];
  assign by = cen_q[3*COORD_W-1 -: COORD_W];
  assign cx = cen_q[2*COORD_W-1 -: COORD_W];
  assign cy = cen_q[1*COORD_W-1 -: COORD_W];
  assign ar = rad_q[3*COORD_W-1 -: COORD_W];
  assign br = rad_q[2*COORD_W-1 -: COORD_W];
  assign cr = rad_q[1*COORD_W-1 -: COORD_W];

  // Squared distance vs squared radius, full width so nothing truncates.
  function automatic logic in_circle(
    input logic [COORD_W-1:0] px,
    input logic [COORD_W-1:0] py,
    input logic [COORD_W-1:0] kx,
    input logic [COORD_W-1:0] ky,
    input logic [COORD_W-1:0] kr
  );
    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    logic [SQ_W-1:0]    d2;
    logic [SQ_W-1:0]    r2;
    dx = (px >= kx) ? (px - kx) : (kx - px);
    dy = (py >= ky) ? (py - ky) : (ky - py);
    d2 = SQ_W'(dx) * SQ_W'(dx) + SQ_W'(dy) * SQ_W'(dy);
    r2 = SQ_W'(kr) * SQ_W'(kr);
    return (d2 <= r2);
  endfunction

  // Set expression selected by mode; reserved codes count nothing.
  function automatic logic set_hit(
    input logic [2:0] m,
    input logic       a,
    input logic       b,
    input logic       c
  );
    logic [1:0] n;
    logic       h;
    n = {1'b0, a} + {1'b0, b} + {1'b0, c};
    case (m)
      3'b000:  h = a;
      3'b001:  h = a & b;
      3'b010:  h = a ^ b;
      3'b011:  h = (n == 2'd2);
      3'b100:  h = a | b | c;
      3'b101:  h = (n == 2'd3);
      default: h = 1'b0;
    endcase
    return h;
  endfunction

  // One evaluation lane per point: lane j handles index base+j.
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [IDX_W-1:0]   k;
    logic [COORD_W-1:0] px;
    logic [COORD_W-1:0] py;
    logic               ia;
    logic               ib;
    logic               ic;
    assign k  = base + IDX_W'(j);
    assign px = COORD_W'(k % IDX_W'(GRID_N)) + COORD_W'(1);
    assign py = COORD_W'(k / IDX_W'(GRID_N)) + COORD_W'(1);
    assign ia = in_circle(px, py, ax, ay, ar);
    assign ib = in_circle(px, py, bx, by, br);
    assign ic = in_circle(px, py, cx, cy, cr);
    assign lane_hit[j] = set_hit(mode_q, ia, ib, ic);
  end

  // Popcount of the lane results for this cycle.
  always_comb begin
    hit_cnt = '0;
    for (int j = 0; j < LANES; j++) begin
      hit_cnt = hit_cnt + CNT_W'(lane_hit[j]);
    end
  end

  // Job sequencer: capture, one load cycle, P run cycles, result pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      valid     <= 1'b0;
      candidate <= '0;
      acc       <= '0;
      base      <= '0;
      cen_q     <= '0;
      rad_q     <= '0;
      mode_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (en && !busy) begin
            cen_q  <= central;
            rad_q  <= radius;
            mode_q <= mode;
            busy   <= 1'b1;
            acc    <= '0;
            base   <= '0;
            state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          state <= S_RUN;
        end
        S_RUN: begin
          acc <= acc + hit_cnt;
          if (base == IDX_W'(LAST_BASE)) begin
            state <= S_DONE;
          end else begin
            base <= base + IDX_W'(LANES);
          end
        end
        S_DONE: begin
          // First DONE edge publishes the result, second retires the job.
          if (!valid) begin
            candidate <= acc;
            valid     <= 1'b1;
          end else begin
            valid <= 1'b0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_set_count_gen.sv
// Bench for set_count_gen: default 8x8/4-lane instance plus a 6x6/3-lane
// instance. Drivers push expected counts and start cycles; monitors pop them
// whenever valid is seen and compare count and latency.
module tb_set_count_gen;

  // Clock and reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic        en8, en6;
  logic [23:0] cen8, cen6;
  logic [11:0] rad8, rad6;
  logic [2:0]  mode8, mode6;
  logic        busy8, valid8, busy6, valid6;
  logic [6:0]  cand8, cand6;

  set_count_gen #(.GRID_N(8), .COORD_W(4), .LANES(4), .CNT_W(7)) dut8 (
    .clk(clk), .rst(rst), .en(en8), .central(cen8), .radius(rad8),
    .mode(mode8), .busy(busy8), .valid(valid8), .candidate(cand8)
  );

  set_count_gen #(.GRID_N(6), .COORD_W(4), .LANES(3), .CNT_W(7)) dut6 (
    .clk(clk), .rst(rst), .en(en6), .central(cen6), .radius(rad6),
    .mode(mode6), .busy(busy6), .valid(valid6), .candidate(cand6)
  );

  // Scoreboard queues
  logic [6:0] exp8_q[$];
  logic [6:0] exp6_q[$];
  int         st8_q[$];
  int         st6_q[$];

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: direct geometric count over the lattice.
  function automatic int model(input int g, input logic [23:0] c,
                               input logic [11:0] r, input logic [2:0] m);
    int kx[3], ky[3], kr[3];
    int cnt, n;
    bit in_k[3];
    bit h;
    for (int i = 0; i < 3; i++) begin
      kx[i] = int'(c[23-8*i -: 4]);
      ky[i] = int'(c[19-8*i -: 4]);
      kr[i] = int'(r[11-4*i -: 4]);
    end
    cnt = 0;
    for (int y = 1; y <= g; y++) begin
      for (int x = 1; x <= g; x++) begin
        n = 0;
        for (int i = 0; i < 3; i++) begin
          in_k[i] = ((x - kx[i]) * (x - kx[i]) + (y - ky[i]) * (y - ky[i])) <= kr[i] * kr[i];
          n += int'(in_k[i]);
        end
        case (m)
          3'd0: h = in_k[0];
          3'd1: h = in_k[0] && in_k[1];
          3'd2: h = in_k[0] != in_k[1];
          3'd3: h = (n == 2);
          3'd4: h = (n >= 1);
          3'd5: h = (n == 3);
          default: h = 1'b0;
        endcase
        cnt += int'(h);
      end
    end
    return cnt;
  endfunction

  // Monitors
  always @(posedge clk) begin
    #1;
    if (!rst && valid8) begin
      if (exp8_q.size() == 0) begin
        check("unexpected_valid8", 1, 0);
      end else begin
        check("cand8", int'(cand8), int'(exp8_q.pop_front()));
        check("latency8", cyc - st8_q.pop_front(), 18);
      end
    end
    if (!rst && valid6) begin
      if (exp6_q.size() == 0) begin
        check("unexpected_valid6", 1, 0);
      end else begin
        check("cand6", int'(cand6), int'(exp6_q.pop_front()));
        check("latency6", cyc - st6_q.pop_front(), 14);
      end
    end
  end

  // Driver tasks
  task automatic drive(input int sel, input logic e, input logic [23:0] c,
                       input logic [11:0] r, input logic [2:0] m);
    if (sel != 0) begin
      en6 = e; cen6 = c; rad6 = r; mode6 = m;
    end else begin
      en8 = e; cen8 = c; rad8 = r; mode8 = m;
    end
  endtask

  function automatic logic busy_of(input int sel);
    return (sel != 0) ? busy6 : busy8;
  endfunction

  task automatic run_job(input int sel, input logic [23:0] c, input logic [11:0] r,
                         input logic [2:0] m, input int exp, input bit noise);
    int p, waitc;
    bit bad;
    p = (sel != 0) ? 12 : 16;
    waitc = 0;
    while (busy_of(sel) && waitc < 60) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (busy_of(sel)) begin
      check("idle_timeout", 1, 0);
      return;
    end
    @(negedge clk);
    drive(sel, 1'b1, c, r, m);
    @(posedge clk); #1;
    if (sel != 0) begin
      exp6_q.push_back(7'(exp)); st6_q.push_back(cyc);
    end else begin
      exp8_q.push_back(7'(exp)); st8_q.push_back(cyc);
    end
    // Scramble inputs after capture: the running job must not see them.
    drive(sel, 1'b0, 24'($urandom), 12'($urandom), 3'($urandom_range(0, 7)));
    bad = !busy_of(sel);
    for (int i = 1; i <= p + 2; i++) begin
      @(posedge clk); #1;
      if (!busy_of(sel)) bad = 1'b1;
      if (noise && i == 4)
        drive(sel, 1'b1, 24'h1234_56, 12'hfff, 3'b100);
      if (noise && i == 5)
        drive(sel, 1'b0, 24'h0, 12'h0, 3'b000);
      if (noise && i == p + 2)
        drive(sel, 1'b1, 24'h8888_88, 12'hfff, 3'b100);
    end
    check("busy_window", int'(bad), 0);
    @(posedge clk); #1;
    drive(sel, 1'b0, 24'h0, 12'h0, 3'b000);
    check("busy_drop", int'(busy_of(sel)), 0);
    check("cand_hold", (sel != 0) ? int'(cand6) : int'(cand8), exp);
  endtask

  task automatic rand_job(input int sel);
    logic [23:0] c;
    logic [11:0] r;
    logic [2:0]  m;
    c = 24'($urandom);
    r = 12'($urandom);
    m = 3'($urandom_range(0, 7));
    run_job(sel, c, r, m, model((sel != 0) ? 6 : 8, c, r, m), 1'($urandom_range(0, 1)));
  endtask

  // Frequently used circle sets
  localparam logic [23:0] C_A44  = {4'd4, 4'd4, 16'h0};
  localparam logic [11:0] R_A2   = {4'd2, 8'h0};
  localparam logic [23:0] C_AB   = {4'd1, 4'd1, 4'd8, 4'd8, 8'h0};
  localparam logic [11:0] R_AB   = {4'd1, 4'd1, 4'd0};
  localparam logic [23:0] C_ABC  = {4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4};
  localparam logic [11:0] R_ABC  = {4'd2, 4'd2, 4'd0};

  // Stimulus sequence
  initial begin
    rst = 1'b1;
    drive(0, 1'b0, 24'h0, 12'h0, 3'b000);
    drive(1, 1'b0, 24'h0, 12'h0, 3'b000);
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy8", int'(busy8), 0);
    check("rst_valid8", int'(valid8), 0);
    check("rst_cand8", int'(cand8), 0);
    check("rst_busy6", int'(busy6), 0);
    check("rst_valid6", int'(valid6), 0);
    check("rst_cand6", int'(cand6), 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases on the default instance
    run_job(0, C_A44, R_A2, 3'b000, 13, 0);
    run_job(0, {4'd8, 4'd8, 16'h0}, {4'd15, 8'h0}, 3'b000, 64, 0);
    run_job(0, 24'h0, 12'h0, 3'b000, 0, 0);
    run_job(0, C_AB, R_AB, 3'b001, 0, 0);
    run_job(0, C_AB, R_AB, 3'b010, 6, 0);
    run_job(0, C_ABC, R_ABC, 3'b011, 12, 0);
    run_job(0, C_ABC, R_ABC, 3'b100, 13, 0);
    run_job(0, C_ABC, R_ABC, 3'b101, 1, 0);
    run_job(0, C_ABC, R_ABC, 3'b110, 0, 0);
    run_job(0, C_ABC, R_ABC, 3'b111, 0, 0);
    run_job(0, C_A44, R_A2, 3'b000, 13, 1);

    // Abort mid-job with an asynchronous reset
    @(negedge clk);
    drive(0, 1'b1, C_A44, R_A2, 3'b000);
    @(posedge clk); #1;
    drive(0, 1'b0, C_A44, R_A2, 3'b000);
    repeat (7) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("abort_busy8", int'(busy8), 0);
    check("abort_valid8", int'(valid8), 0);
    check("abort_cand8", int'(cand8), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("abort_idle8", int'(busy8), 0);
    run_job(0, C_A44, R_A2, 3'b000, 13, 0);

    for (int i = 0; i < 20; i++) rand_job(0);

    // Alternate geometry: 6x6 lattice, 3 lanes
    run_job(1, {4'd3, 4'd3, 16'h0}, {4'd15, 8'h0}, 3'b000, 36, 0);
    run_job(1, {4'd3, 4'd3, 16'h0}, {4'd1, 8'h0}, 3'b000, 5, 0);
    for (int i = 0; i < 10; i++) rand_job(1);

    repeat (4) @(posedge clk);
    #1;
    check("pending8", exp8_q.size(), 0);
    check("pending6", exp6_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
